// File: rtl/pipelined_barrel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter_if
// Brief    : Operand-in / result-out valid-ready bundle for the barrel shifter.
// Revision : 1.0
// ============================================================================
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sh_mode;
    logic [LOG2W-1:0] sh_amt;
    logic [WIDTH-1:0] d_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;
    logic [TAG_W-1:0] tag_out;
    logic             out_zero;

    modport master (
        output in_valid, sh_mode, sh_amt, d_in, tag_in, out_ready,
        input  in_ready, out_valid, d_out, tag_out, out_zero
    );

    modport slave (
        input  in_valid, sh_mode, sh_amt, d_in, tag_in, out_ready,
        output in_ready, out_valid, d_out, tag_out, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : log2(WIDTH)-stage SLL/SRL/SRA/ROR shifter, whole-pipe stall.
// Revision : 1.0
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       mode,
        input logic             fill,
        input int unsigned      s
    );
        logic [WIDTH-1:0] fill_mask;
        fill_mask = ~({WIDTH{1'b1}} >> s);
        case (mode)
            MODE_SLL: shift_by = x << s;
            MODE_SRL: shift_by = x >> s;
            MODE_SRA: shift_by = (x >> s) | (fill ? fill_mask : '0);
            default:  shift_by = (x >> s) | (x << (WIDTH - s));
        endcase
    endfunction

    logic stall;

    // src_* is what stage k consumes: the input port for k=0, stage k-1 otherwise
    logic [WIDTH-1:0] src_data  [LOG2W];
    logic [TAG_W-1:0] src_tag   [LOG2W];
    logic [1:0]       src_mode  [LOG2W];
    logic [LOG2W-1:0] src_amt   [LOG2W];
    logic             src_fill  [LOG2W];
    logic             src_valid [LOG2W];
    logic [WIDTH-1:0] nxt_data  [LOG2W];

    logic [WIDTH-1:0] stg_data  [LOG2W];
    logic [TAG_W-1:0] stg_tag   [LOG2W];
    logic [1:0]       stg_mode  [LOG2W];
    logic [LOG2W-1:0] stg_amt   [LOG2W];
    logic             stg_fill  [LOG2W];
    logic             stg_valid [LOG2W];
    logic             zero_q;

    assign stall         = stg_valid[LOG2W-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = stg_valid[LOG2W-1];
    assign bus.d_out     = stg_data[LOG2W-1];
    assign bus.tag_out   = stg_tag[LOG2W-1];
    assign bus.out_zero  = zero_q;

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        localparam int unsigned SHIFT = 1 << k;

        if (k == 0) begin : g_head
            assign src_data[k]  = bus.d_in;
            assign src_tag[k]   = bus.tag_in;
            assign src_mode[k]  = bus.sh_mode;
            assign src_amt[k]   = bus.sh_amt;
            assign src_fill[k]  = bus.d_in[WIDTH-1];
            assign src_valid[k] = bus.in_valid;
        end else begin : g_link
            assign src_data[k]  = stg_data[k-1];
            assign src_tag[k]   = stg_tag[k-1];
            assign src_mode[k]  = stg_mode[k-1];
            assign src_amt[k]   = stg_amt[k-1];
            assign src_fill[k]  = stg_fill[k-1];
            assign src_valid[k] = stg_valid[k-1];
        end

        assign nxt_data[k] = src_amt[k][k]
                           ? shift_by(src_data[k], src_mode[k], src_fill[k], SHIFT)
                           : src_data[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LOG2W; i++) begin
                stg_data[i]  <= '0;
                stg_tag[i]   <= '0;
                stg_mode[i]  <= '0;
                stg_amt[i]   <= '0;
                stg_fill[i]  <= 1'b0;
                stg_valid[i] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < LOG2W; i++) begin
                stg_data[i]  <= nxt_data[i];
                stg_tag[i]   <= src_tag[i];
                stg_mode[i]  <= src_mode[i];
                stg_amt[i]   <= src_amt[i];
                stg_fill[i]  <= src_fill[i];
                stg_valid[i] <= src_valid[i];
            end
            zero_q <= (nxt_data[LOG2W-1] == '0);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Brief    : Directed self-checking bench for pipelined_barrel_shifter.
// Revision : 1.0
// ============================================================================
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [1:0]  b_mode [8] = '{SLL, SRL, SRA, ROR, SLL, SRA, ROR, SRL};
    logic [4:0]  b_amt  [8] = '{5'd4, 5'd1, 5'd1, 5'd4, 5'd16, 5'd12, 5'd1, 5'd7};
    logic [31:0] b_din  [8] = '{32'h0000000F, 32'h80000000, 32'h80000000, 32'h0000000F,
                                32'hA5A5A5A5, 32'hF0F0F0F0, 32'h00000001, 32'hFFFFFFFF};
    logic [31:0] b_exp  [8] = '{32'h000000F0, 32'h40000000, 32'hC0000000, 32'hF0000000,
                                32'hA5A50000, 32'hFFFF0F0F, 32'h80000000, 32'h01FFFFFF};
    logic        gap_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] t);
        bus.in_valid = v;
        bus.sh_mode  = m;
        bus.sh_amt   = a;
        bus.d_in     = d;
        bus.tag_in   = t;
    endtask

    task automatic send_and_check(input string name, input logic [1:0] m, input logic [4:0] a,
                                  input logic [31:0] d, input logic [3:0] t, input logic [31:0] exp);
        int edges;
        @(posedge clk); #1;
        drive(1'b1, m, a, d, t);
        @(posedge clk);
        edges = 1;
        #1;
        drive(1'b0, 2'b00, 5'd0, 32'h0, 4'h0);
        @(negedge clk);
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_value({name, "_latency"}, 32'(edges), 32'd5);
        check_value({name, "_data"}, bus.d_out, exp);
        check_value({name, "_tag"}, 32'(bus.tag_out), 32'(t));
        check_value({name, "_zero"}, 32'(bus.out_zero), 32'(exp == 32'h0));
    endtask

    task automatic burst_with_stall();
        @(posedge clk); #1;
        fork
            begin : driver
                int  i;
                logic acc;
                i = 0;
                while (i < 8) begin
                    drive(1'b1, b_mode[i], b_amt[i], b_din[i], 4'(i));
                    @(negedge clk);
                    acc = bus.in_ready;
                    @(posedge clk); #1;
                    if (acc) i++;
                end
                drive(1'b0, 2'b00, 5'd0, 32'h0, 4'h0);
            end
            begin : ready_ctl
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
            begin : receiver
                int k;
                int stalls;
                k = 0;
                stalls = 0;
                for (int c = 0; c < 60 && k < 8; c++) begin
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        check_value("burst_data", bus.d_out, b_exp[k]);
                        check_value("burst_tag", 32'(bus.tag_out), 32'(k));
                        k++;
                    end else if (bus.out_valid) begin
                        stalls++;
                        check_value("stall_in_ready", 32'(bus.in_ready), 32'd0);
                        check_value("stall_hold_data", bus.d_out, b_exp[k]);
                        check_value("stall_hold_tag", 32'(bus.tag_out), 32'(k));
                    end
                end
                check_value("burst_count", 32'(k), 32'd8);
                check_value("burst_stall_cycles", 32'(stalls), 32'd4);
            end
        join
    endtask

    task automatic gap_stream();
        logic exp_v;
        @(posedge clk); #1;
        for (int j = 0; j < 12; j++) begin
            if (j < 5) drive(gap_pat[j], SLL, 5'd1, 32'(j + 1), 4'(j));
            else       drive(1'b0, SLL, 5'd0, 32'h0, 4'h0);
            @(negedge clk);
            exp_v = (j >= 5 && j < 10) ? gap_pat[j-5] : 1'b0;
            check_value($sformatf("gap_valid_%0d", j), 32'(bus.out_valid), 32'(exp_v));
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_midflight();
        int seen;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(1'b1, SLL, 5'd3, 32'h00000001, 4'h9); @(posedge clk); #1;
        drive(1'b1, SRL, 5'd4, 32'h00000100, 4'h5); @(posedge clk); #1;
        drive(1'b1, ROR, 5'd1, 32'h00000003, 4'h6); @(posedge clk); #1;
        drive(1'b0, SLL, 5'd0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check_value("pre_rst_data", bus.d_out, 32'h00000008);
        #2 rst = 1'b1;
        #1;
        check_value("rst_async_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_async_data", bus.d_out, 32'h0);
        check_value("rst_async_tag", 32'(bus.tag_out), 32'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_value("post_rst_stale", 32'(seen), 32'd0);
        send_and_check("post_rst_op", SRA, 5'd16, 32'hFFFF0000, 4'hA, 32'hFFFFFFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 2'b00, 5'd0, 32'h0, 4'h0);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_d_out", bus.d_out, 32'h0);
        check_value("rst_tag_out", 32'(bus.tag_out), 32'h0);
        check_value("rst_out_zero", 32'(bus.out_zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send_and_check("sra_sign", SRA, 5'd8,  32'h80000000, 4'd3, 32'hFF800000);
        send_and_check("sll_8",    SLL, 5'd8,  32'h000000FF, 4'd1, 32'h0000FF00);
        send_and_check("srl_31",   SRL, 5'd31, 32'hF0000000, 4'd2, 32'h00000001);
        send_and_check("ror_4",    ROR, 5'd4,  32'h12345678, 4'd4, 32'h81234567);
        send_and_check("ror_31",   ROR, 5'd31, 32'h00000001, 4'd5, 32'h00000002);
        send_and_check("sra_pos",  SRA, 5'd4,  32'h7FFFFFFF, 4'd6, 32'h07FFFFFF);
        send_and_check("sll_amt0", SLL, 5'd0,  32'hDEADBEEF, 4'd7, 32'hDEADBEEF);
        send_and_check("srl_amt0", SRL, 5'd0,  32'hDEADBEEF, 4'd8, 32'hDEADBEEF);
        send_and_check("sra_amt0", SRA, 5'd0,  32'hDEADBEEF, 4'd9, 32'hDEADBEEF);
        send_and_check("ror_amt0", ROR, 5'd0,  32'hDEADBEEF, 4'd10, 32'hDEADBEEF);
        send_and_check("sll_31",   SLL, 5'd31, 32'h00000001, 4'd11, 32'h80000000);
        send_and_check("srl_zero", SRL, 5'd31, 32'h00000001, 4'd12, 32'h00000000);

        burst_with_stall();
        gap_stream();
        reset_midflight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
